// File: rtl/pcie_usp_rq_arb_pkg.sv
// Shared types and constants for the UltraScale+ PCIe RQ request arbiter.
package pcie_usp_rq_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  localparam int RQ_USER_W_STD = 62;   // 64/128/256-bit cores
  localparam int RQ_USER_W_512 = 137;  // 512-bit core

  function automatic int src_idx_w(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/pcie_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N.
module pcie_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= N) sum = sum - N;
    return IDX_W'(sum);
  endfunction

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = wrap_add(ptr, k);
      if (!any && req[cand]) begin
        any          = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_usp_rq_arb.sv
// Packet-granular round-robin arbiter onto the PCIe RQ AXI-stream.
// Define PCIE_RQ_ARB_NPH_GATE_EN to hold non-posted packets until enough NP-header credit is available.
module pcie_usp_rq_arb
  import pcie_usp_rq_arb_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 32,
  parameter int RQ_USER_WIDTH = (DATA_WIDTH == 512) ? RQ_USER_W_512 : RQ_USER_W_STD,
  parameter int NPH_THRESH    = 1,
  localparam int IDX_W        = src_idx_w(N_SRC)
) (
  input  logic                          user_clk,
  input  logic                          user_reset_n,
  input  logic [N_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_SRC*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [N_SRC-1:0]              s_axis_tlast,
  input  logic [N_SRC*RQ_USER_WIDTH-1:0] s_axis_tuser,
  input  logic [N_SRC-1:0]              s_axis_tvalid,
  output logic [N_SRC-1:0]              s_axis_tready,
  input  logic [N_SRC-1:0]              s_req_np,
  output logic [DATA_WIDTH-1:0]         m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_rq_tkeep,
  output logic                          m_axis_rq_tlast,
  output logic [RQ_USER_WIDTH-1:0]      m_axis_rq_tuser,
  output logic                          m_axis_rq_tvalid,
  input  logic [3:0]                    m_axis_rq_tready,
  input  logic [3:0]                    pcie_tfc_nph_av,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [N_SRC-1:0] grant_oh_q, grant_oh_d;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             pass;

`ifdef PCIE_RQ_ARB_NPH_GATE_EN
  logic nph_ok;
  logic unused_in;
  assign nph_ok    = (pcie_tfc_nph_av >= 4'(NPH_THRESH));
  assign eligible  = s_axis_tvalid & ~(s_req_np & {N_SRC{~nph_ok}});
  assign unused_in = ^m_axis_rq_tready[3:1];
`else
  logic unused_in;
  assign eligible  = s_axis_tvalid;
  assign unused_in = ^{s_req_np, pcie_tfc_nph_av, m_axis_rq_tready[3:1]};
`endif

  pcie_rr_arb #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Data path is a pure mux of the granted source; only control is registered.
  assign pass             = (state_q == ARB_PASS);
  assign m_axis_rq_tdata  = s_axis_tdata[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_rq_tkeep  = s_axis_tkeep[int'(grant_idx_q)*KEEP_WIDTH +: KEEP_WIDTH];
  assign m_axis_rq_tuser  = s_axis_tuser[int'(grant_idx_q)*RQ_USER_WIDTH +: RQ_USER_WIDTH];
  assign m_axis_rq_tlast  = s_axis_tlast[grant_idx_q];
  assign m_axis_rq_tvalid = pass & s_axis_tvalid[grant_idx_q];
  assign s_axis_tready    = pass ? (grant_oh_q & {N_SRC{m_axis_rq_tready[0]}}) : '0;
  assign grant_valid      = pass;
  assign grant_idx        = grant_idx_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_PASS;
          grant_idx_d = pick_idx;
          grant_oh_d  = pick_oh;
        end
      end
      ARB_PASS: begin
        // Credit is not re-checked here: a granted packet always runs to tlast.
        if (m_axis_rq_tvalid && m_axis_rq_tready[0] && m_axis_rq_tlast) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_idx_q == IDX_W'(N_SRC - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
    end
  end

endmodule

// File: tb/tb_pcie_usp_rq_arb.sv
// Self-checking bench for pcie_usp_rq_arb: packet-queue source models plus a round-robin reference model.
`timescale 1ns/1ps
module tb_pcie_usp_rq_arb;

  localparam int N          = 4;
  localparam int DW         = 64;
  localparam int KW         = DW / 32;
  localparam int UW         = 62;
  localparam int IW         = 2;
  localparam int NPH_THRESH = 1;

  logic            user_clk = 1'b0;
  logic            user_reset_n;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic [N*UW-1:0] s_axis_tuser;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N-1:0]    s_req_np;
  logic [DW-1:0]   m_axis_rq_tdata;
  logic [KW-1:0]   m_axis_rq_tkeep;
  logic            m_axis_rq_tlast;
  logic [UW-1:0]   m_axis_rq_tuser;
  logic            m_axis_rq_tvalid;
  logic [3:0]      m_axis_rq_tready;
  logic [3:0]      pcie_tfc_nph_av;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;

  pcie_usp_rq_arb #(
    .N_SRC(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .RQ_USER_WIDTH(UW), .NPH_THRESH(NPH_THRESH)
  ) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_req_np(s_req_np),
    .m_axis_rq_tdata(m_axis_rq_tdata), .m_axis_rq_tkeep(m_axis_rq_tkeep),
    .m_axis_rq_tlast(m_axis_rq_tlast), .m_axis_rq_tuser(m_axis_rq_tuser),
    .m_axis_rq_tvalid(m_axis_rq_tvalid), .m_axis_rq_tready(m_axis_rq_tready),
    .pcie_tfc_nph_av(pcie_tfc_nph_av), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    int          len;
    bit          np;
    int unsigned salt;
  } pkt_t;

  pkt_t pq[N][$];          // pending packets per source, head is the one being offered
  int   beat_no[N];
  int   gap[N];            // cycles the source keeps tvalid low before its next beat
  int   owner = -1;        // reference model: source owning the output, -1 when none
  int   ptr   = 0;         // reference model: round-robin start point
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_log[$];
  int   xfer_src[$];
  int   xfer_cyc[$];
  int   tr_mode   = 0;     // 0: ready high, 1: toggle, 2: random
  bit   tr_phase  = 1'b0;
  bit   nph_rand  = 1'b0;
  bit   rnd_gap   = 1'b0;
  int   stall_src = -1;
  int   stall_beat = 0;
  int   stall_len  = 0;
  int   stalled_cycles = 0;

  function automatic logic [DW-1:0] exp_data(input int s, input int unsigned salt, input int b);
    return {8'(s), 8'(b), 16'(salt), 32'(salt * 32'h9E37_79B1 + 32'(b))};
  endfunction

  function automatic logic [KW-1:0] exp_keep(input int unsigned salt, input int b);
    return KW'(salt >> b);
  endfunction

  function automatic logic [UW-1:0] exp_user(input int unsigned salt, input int b);
    return UW'({salt ^ 32'h5A5A_0F0F, salt + 32'(b)});
  endfunction

  function automatic int log_code();
    int c;
    c = 0;
    foreach (done_log[i]) c = c * 10 + done_log[i] + 1;
    return c;
  endfunction

  task automatic push_pkt(input int s, input int len, input bit np);
    pkt_t p;
    p.len  = len;
    p.np   = np;
    p.salt = $urandom;
    pq[s].push_back(p);
  endtask

  task automatic drive();
    logic b0;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && gap[i] == 0) begin
        pkt_t p;
        p = pq[i][0];
        s_axis_tvalid[i]         = 1'b1;
        s_axis_tdata[i*DW +: DW] = exp_data(i, p.salt, beat_no[i]);
        s_axis_tkeep[i*KW +: KW] = exp_keep(p.salt, beat_no[i]);
        s_axis_tuser[i*UW +: UW] = exp_user(p.salt, beat_no[i]);
        s_axis_tlast[i]          = (beat_no[i] == p.len - 1);
        s_req_np[i]              = p.np;
      end else begin
        s_axis_tvalid[i]         = 1'b0;
        s_axis_tdata[i*DW +: DW] = {$urandom, $urandom};
        s_axis_tkeep[i*KW +: KW] = KW'($urandom);
        s_axis_tuser[i*UW +: UW] = UW'({$urandom, $urandom});
        s_axis_tlast[i]          = 1'($urandom);
        s_req_np[i]              = 1'($urandom);
      end
    end
    case (tr_mode)
      0:       b0 = 1'b1;
      1:       begin tr_phase = ~tr_phase; b0 = tr_phase; end
      default: b0 = 1'($urandom_range(0, 1));
    endcase
    m_axis_rq_tready = {3'($urandom), b0};
    if (nph_rand) pcie_tfc_nph_av = 4'($urandom_range(0, 2));
  endtask

  // Called mid-low-phase: checks outputs against the model, then advances sources and model.
  task automatic sample();
    logic         mt0;
    logic         nph_ok;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    pkt_t         p;
    cyc++;
    mt0 = m_axis_rq_tready[0];
`ifdef PCIE_RQ_ARB_NPH_GATE_EN
    nph_ok = (pcie_tfc_nph_av >= 4'(NPH_THRESH));
`else
    nph_ok = 1'b1;
`endif
    if (!user_reset_n) begin
      owner = -1;
      ptr   = 0;
      n_tests++;
      if ({grant_valid, grant_idx, m_axis_rq_tvalid, s_axis_tready} !== '0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d: got gv=%b gi=%0d tv=%b rdy=%b, want all zero",
                 cyc, grant_valid, grant_idx, m_axis_rq_tvalid, s_axis_tready);
      end
      return;
    end
    exp_rdy = '0;
    if (owner >= 0) exp_rdy[owner] = mt0;
    n_tests++;
    if (owner >= 0) begin
      if (grant_valid !== 1'b1 || grant_idx !== IW'(owner) ||
          m_axis_rq_tvalid !== s_axis_tvalid[owner] || s_axis_tready !== exp_rdy) begin
        n_fail++;
        $display("FAIL grant_ctl cyc=%0d: got gv=%b gi=%0d tv=%b rdy=%b, want gv=1 gi=%0d tv=%b rdy=%b",
                 cyc, grant_valid, grant_idx, m_axis_rq_tvalid, s_axis_tready,
                 owner, s_axis_tvalid[owner], exp_rdy);
      end
      if (!s_axis_tvalid[owner]) stalled_cycles++;
    end else if (grant_valid !== 1'b0 || m_axis_rq_tvalid !== 1'b0 || s_axis_tready !== '0) begin
      n_fail++;
      $display("FAIL idle_ctl cyc=%0d: got gv=%b tv=%b rdy=%b, want 0 0 0",
               cyc, grant_valid, m_axis_rq_tvalid, s_axis_tready);
    end
    if (owner >= 0 && s_axis_tvalid[owner]) begin
      p = pq[owner][0];
      n_tests++;
      if (m_axis_rq_tdata !== exp_data(owner, p.salt, beat_no[owner]) ||
          m_axis_rq_tkeep !== exp_keep(p.salt, beat_no[owner]) ||
          m_axis_rq_tuser !== exp_user(p.salt, beat_no[owner]) ||
          m_axis_rq_tlast !== (beat_no[owner] == p.len - 1)) begin
        n_fail++;
        $display("FAIL beat src%0d beat%0d cyc=%0d: got d=%h k=%h l=%b u=%h, want d=%h k=%h l=%b u=%h",
                 owner, beat_no[owner], cyc, m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast,
                 m_axis_rq_tuser, exp_data(owner, p.salt, beat_no[owner]),
                 exp_keep(p.salt, beat_no[owner]), (beat_no[owner] == p.len - 1),
                 exp_user(p.salt, beat_no[owner]));
      end
    end
    for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
    hs = s_axis_tvalid & s_axis_tready;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        xfer_src.push_back(i);
        xfer_cyc.push_back(cyc);
        if (s_axis_tlast[i]) begin
          pq[i].delete(0);
          beat_no[i] = 0;
          done_log.push_back(i);
        end else begin
          beat_no[i]++;
          if (i == stall_src && beat_no[i] == stall_beat) begin
            gap[i]    = stall_len;
            stall_src = -1;
          end else if (rnd_gap && $urandom_range(0, 3) == 0) begin
            gap[i] = $urandom_range(1, 2);
          end
        end
      end
    end
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (s_axis_tvalid[c] && (!s_req_np[c] || nph_ok)) begin
          owner = c;
          break;
        end
      end
    end else if (s_axis_tvalid[owner] && mt0 && s_axis_tlast[owner]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end
  endtask

  task automatic cycle();
    @(negedge user_clk);
    sample();
    @(posedge user_clk);
    #1;
    drive();
  endtask

  task automatic clear_logs();
    done_log.delete();
    xfer_src.delete();
    xfer_cyc.delete();
  endtask

  task automatic apply_reset();
    user_reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      beat_no[i] = 0;
      gap[i]     = 0;
    end
    stall_src = -1;
    rnd_gap   = 1'b0;
    tr_mode   = 0;
    nph_rand  = 1'b0;
    pcie_tfc_nph_av = 4'd0;
    drive();
    repeat (2) cycle();
    user_reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until_done(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (done_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    n_tests++;
    if (done_log.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d packets, want %0d", name, done_log.size(), n);
    end
  endtask

  task automatic test_reset();
    user_reset_n = 1'b0;
    for (int i = 0; i < N; i++) push_pkt(i, 1, 1'b0);
    drive();
    repeat (3) cycle();
    user_reset_n = 1'b1;
    clear_logs();
    run_until_done(4, 40, "reset_release");
    n_tests++;
    if (log_code() !== 1234) begin
      n_fail++;
      $display("FAIL reset_order: got %0d, want 1234", log_code());
    end
  endtask

  task automatic test_packet_rr();
    int c0, sc, oc;
    apply_reset();
    push_pkt(0, 3, 1'b0);
    push_pkt(2, 3, 1'b0);
    drive();
    c0 = cyc;
    run_until_done(2, 40, "packet_rr");
    sc = 0;
    oc = 0;
    foreach (xfer_src[i]) sc = sc * 10 + xfer_src[i] + 1;
    foreach (xfer_cyc[i]) oc = oc * 10 + (xfer_cyc[i] - c0);
    n_tests++;
    if (sc !== 111333 || oc !== 234678) begin
      n_fail++;
      $display("FAIL packet_rr_timing: got src=%0d ofs=%0d, want src=111333 ofs=234678", sc, oc);
    end
    clear_logs();
    push_pkt(1, 1, 1'b0);
    push_pkt(3, 1, 1'b0);
    drive();
    run_until_done(2, 20, "ptr_after_src2");
    n_tests++;
    if (log_code() !== 42) begin
      n_fail++;
      $display("FAIL ptr_after_src2: got %0d, want 42", log_code());
    end
  endtask

  task automatic test_all_valid();
    int bad;
    apply_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1, 1'b0);
    drive();
    run_until_done(8, 40, "all_valid");
    n_tests++;
    if (log_code() !== 12341234) begin
      n_fail++;
      $display("FAIL all_valid_order: got %0d, want 12341234", log_code());
    end
    bad = 0;
    for (int i = 1; i < xfer_cyc.size(); i++) if (xfer_cyc[i] - xfer_cyc[i-1] != 2) bad++;
    n_tests++;
    if (bad !== 0 || xfer_cyc.size() !== 8) begin
      n_fail++;
      $display("FAIL all_valid_spacing: got %0d bad gaps over %0d beats, want 0 over 8", bad, xfer_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int oc, c0;
    apply_reset();
    for (int r = 0; r < 3; r++) push_pkt(2, 1, 1'b0);
    drive();
    c0 = cyc;
    run_until_done(3, 30, "back_to_back");
    oc = 0;
    foreach (xfer_cyc[i]) oc = oc * 10 + (xfer_cyc[i] - c0);
    n_tests++;
    if (oc !== 246) begin
      n_fail++;
      $display("FAIL back_to_back_ofs: got %0d, want 246", oc);
    end
  endtask

  task automatic test_tready_toggle();
    int sc;
    apply_reset();
    tr_mode = 1;
    push_pkt(1, 4, 1'b0);
    push_pkt(3, 2, 1'b0);
    drive();
    run_until_done(2, 60, "tready_toggle");
    sc = 0;
    foreach (xfer_src[i]) sc = sc * 10 + xfer_src[i] + 1;
    n_tests++;
    if (sc !== 222244) begin
      n_fail++;
      $display("FAIL tready_toggle_beats: got %0d, want 222244", sc);
    end
  endtask

  task automatic test_np_gate();
    apply_reset();
    push_pkt(0, 1, 1'b0);
    drive();
    run_until_done(1, 20, "np_setup");
    clear_logs();
    pcie_tfc_nph_av = 4'd0;
    push_pkt(1, 2, 1'b1);
    push_pkt(2, 2, 1'b0);
    drive();
`ifdef PCIE_RQ_ARB_NPH_GATE_EN
    run_until_done(1, 30, "np_gate_posted");
    repeat (4) cycle();
    n_tests++;
    if (log_code() !== 3) begin
      n_fail++;
      $display("FAIL np_gate_hold: got %0d, want 3", log_code());
    end
    pcie_tfc_nph_av = 4'd2;
    run_until_done(2, 30, "np_gate_release");
    n_tests++;
    if (log_code() !== 32) begin
      n_fail++;
      $display("FAIL np_gate_release: got %0d, want 32", log_code());
    end
    pcie_tfc_nph_av = 4'(NPH_THRESH);
    push_pkt(1, 1, 1'b1);
    drive();
    run_until_done(3, 20, "np_at_threshold");
`else
    run_until_done(2, 30, "np_ungated");
    n_tests++;
    if (log_code() !== 23) begin
      n_fail++;
      $display("FAIL np_ungated_order: got %0d, want 23", log_code());
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    int k;
    apply_reset();
    push_pkt(1, 1, 1'b0);
    drive();
    run_until_done(1, 20, "mid_reset_setup");
    push_pkt(0, 4, 1'b0);
    drive();
    k = 0;
    while (beat_no[0] < 1 && k < 40) begin
      cycle();
      k++;
    end
    user_reset_n = 1'b0;
    #1;
    n_tests++;
    if (m_axis_rq_tvalid !== 1'b0 || grant_valid !== 1'b0 || s_axis_tready !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got tv=%b gv=%b rdy=%b, want 0 0 0",
               m_axis_rq_tvalid, grant_valid, s_axis_tready);
    end
    apply_reset();
    push_pkt(2, 1, 1'b0);
    push_pkt(0, 1, 1'b0);
    drive();
    run_until_done(2, 20, "mid_reset_after");
    n_tests++;
    if (log_code() !== 13) begin
      n_fail++;
      $display("FAIL mid_reset_ptr: got %0d, want 13", log_code());
    end
  endtask

  task automatic test_stall();
    apply_reset();
    push_pkt(1, 4, 1'b0);
    drive();
    cycle();
    push_pkt(0, 1, 1'b0);
    push_pkt(2, 1, 1'b0);
    push_pkt(3, 1, 1'b0);
    stall_src      = 1;
    stall_beat     = 1;
    stall_len      = 3;
    stalled_cycles = 0;
    drive();
    run_until_done(4, 60, "stall");
    n_tests++;
    if (log_code() !== 2341 || stalled_cycles !== 3) begin
      n_fail++;
      $display("FAIL stall_hold: got order=%0d stalled=%0d, want order=2341 stalled=3",
               log_code(), stalled_cycles);
    end
  endtask

  task automatic test_random();
    int total, beats;
    for (int round = 0; round < 3; round++) begin
      apply_reset();
      rnd_gap  = 1'b1;
      tr_mode  = 2;
      nph_rand = 1'b1;
      total    = 0;
      beats    = 0;
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(2, 5);
        for (int j = 0; j < n; j++) begin
          int len;
          len = $urandom_range(1, 4);
          push_pkt(i, len, 1'($urandom_range(0, 1)));
          beats += len;
        end
        total += n;
      end
      drive();
      run_until_done(total, 3000, "random");
      n_tests++;
      if (xfer_src.size() !== beats) begin
        n_fail++;
        $display("FAIL random_beats round%0d: got %0d beats, want %0d", round, xfer_src.size(), beats);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset_n     = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tkeep     = '0;
    s_axis_tlast     = '0;
    s_axis_tuser     = '0;
    s_axis_tvalid    = '0;
    s_req_np         = '0;
    m_axis_rq_tready = 4'h1;
    pcie_tfc_nph_av  = 4'd0;
    for (int i = 0; i < N; i++) begin
      beat_no[i] = 0;
      gap[i]     = 0;
    end
    @(posedge user_clk);
    #1;
    test_reset();
    test_packet_rr();
    test_all_valid();
    test_back_to_back();
    test_tready_toggle();
    test_np_gate();
    test_reset_mid_packet();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
